// File: rtl/mic_dac_scheduler.sv
// Buffers mic3 samples in a small FIFO and replays them to DA2 on a fixed sample-rate tick.
// Optional macro PEAK_HOLD_EN adds a peak-magnitude output over accepted samples.
module mic_dac_scheduler #(
    parameter int DEPTH_LOG2 = 3,
    parameter int SAMPLE_DIV = 2500,
    parameter int PRIME_LVL  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mute,
    input  logic                  clr_flags,
    output logic                  mic_en,
    input  logic [11:0]           mic_data,
    input  logic                  mic_valid,
    input  logic                  dac_ready,
    output logic                  dac_update,
    output logic [11:0]           dac_data,
    output logic [DEPTH_LOG2:0]   fill,
`ifdef PEAK_HOLD_EN
    output logic [10:0]           peak,
`endif
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PRIME_CNT = (DEPTH_LOG2+1)'(PRIME_LVL);
    localparam logic [CW-1:0]       TC        = CW'(SAMPLE_DIV - 1);

    // state | meaning
    // IDLE  | path disabled, FIFO empty, mic gated off
    // PRIME | mic enabled, filling FIFO up to PRIME_LVL
    // RUN   | sample-rate tick active, FIFO drained into DAC
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   pending;
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [11:0]            mem [DEPTH];

    logic active, empty, full, tick, pop, push, drop;

    assign active = en && (state != IDLE);
    assign empty  = (fill == '0);
    assign full   = (fill == FULL_CNT);
    assign tick   = en && (state == RUN) && (cnt == TC);
    assign pop    = en && (state == RUN) && dac_ready && !empty && (pending || tick);
    assign push   = active && mic_valid && (!full || pop);
    assign drop   = active && mic_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= mic_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mic_en     <= 1'b0;
            cnt        <= '0;
            pending    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            dac_update <= 1'b0;
            dac_data   <= 12'h800;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dac_update <= pop;
            if (pop)
                dac_data <= mute ? 12'h800 : mem[rd_ptr];
            overflow  <= drop || (overflow && !clr_flags);
            underflow <= (tick && empty) || (underflow && !clr_flags);

            if (!en) begin
                // disable flushes the FIFO but keeps the last DAC value on the output
                state   <= IDLE;
                mic_en  <= 1'b0;
                cnt     <= '0;
                pending <= 1'b0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                fill    <= '0;
            end else begin
                mic_en <= 1'b1;
                case (state)
                    IDLE:  state <= PRIME;
                    PRIME: if (fill >= PRIME_CNT) begin
                               state <= RUN;
                               cnt   <= '0;
                           end
                    RUN:   cnt <= tick ? '0 : cnt + CW'(1);
                    default: state <= IDLE;
                endcase

                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    fill <= fill + 1'b1;
                else if (pop && !push)
                    fill <= fill - 1'b1;

                // ticks arriving while a pop is already owed are absorbed
                if (pop)
                    pending <= 1'b0;
                else if (tick && !empty)
                    pending <= 1'b1;
            end
        end
    end

`ifdef PEAK_HOLD_EN
    logic [11:0] diff;
    logic [10:0] mag;

    always_comb begin
        diff = 12'h800 - mic_data;
        if (mic_data[11])
            mag = mic_data[10:0];
        else
            mag = diff[11] ? 11'h7FF : diff[10:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= '0;
        else if (clr_flags)
            peak <= push ? mag : 11'h000;
        else if (push && (mag > peak))
            peak <= mag;
    end
`endif

endmodule

// File: tb/tb_mic_dac_scheduler.sv
// Directed bench for mic_dac_scheduler with a short sample period (SAMPLE_DIV=10).
module tb_mic_dac_scheduler;

    localparam int DL2 = 3;
    localparam int DIV = 10;
    localparam int PL  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, mute = 1'b0, clr_flags = 1'b0;
    logic          mic_en;
    logic [11:0]   mic_data = 12'h000;
    logic          mic_valid = 1'b0;
    logic          dac_ready = 1'b1;
    logic          dac_update;
    logic [11:0]   dac_data;
    logic [DL2:0]  fill;
    logic          overflow, underflow;
`ifdef PEAK_HOLD_EN
    logic [10:0]   peak;
`endif

    int checks = 0;
    int errors = 0;
    int nupd;
    logic [11:0] last;

    mic_dac_scheduler #(.DEPTH_LOG2(DL2), .SAMPLE_DIV(DIV), .PRIME_LVL(PL)) dut (
        .clk(clk), .rst(rst), .en(en), .mute(mute), .clr_flags(clr_flags),
        .mic_en(mic_en), .mic_data(mic_data), .mic_valid(mic_valid),
        .dac_ready(dac_ready), .dac_update(dac_update), .dac_data(dac_data),
        .fill(fill),
`ifdef PEAK_HOLD_EN
        .peak(peak),
`endif
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] d);
        mic_data  = d;
        mic_valid = 1'b1;
        step(1);
        mic_valid = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        chk("rst_mic_en", mic_en, 0);
        chk("rst_update", dac_update, 0);
        chk("rst_data", dac_data, 12'h800);
        chk("rst_fill", fill, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // mic_valid in IDLE is ignored
        push(12'h555);
        chk("idle_ignore", fill, 0);

        en = 1'b1;
        step(1);
        chk("mic_en_on", mic_en, 1);

        push(12'h100); push(12'h101); push(12'h3FF); push(12'h103);
        chk("primed_fill", fill, 4);
        // RUN entered next edge, first update SAMPLE_DIV edges after that
        step(10);
        chk("no_early_upd", dac_update, 0);
        step(1);
        chk("upd1", dac_update, 1);
        chk("upd1_data", dac_data, 12'h100);
        chk("upd1_fill", fill, 3);
        step(1);
        chk("upd1_pulse", dac_update, 0);
        step(9);
        chk("upd2", dac_update, 1);
        chk("upd2_data", dac_data, 12'h101);
        chk("upd2_fill", fill, 2);

        mute = 1'b1;
        step(10);
        chk("mute_upd", dac_update, 1);
        chk("mute_data", dac_data, 12'h800);
        chk("mute_fill", fill, 1);
        mute = 1'b0;
        step(10);
        chk("upd4_data", dac_data, 12'h103);
        chk("upd4_fill", fill, 0);
        chk("no_unf_yet", underflow, 0);

        step(10);
        chk("unf_no_upd", dac_update, 0);
        chk("unf_flag", underflow, 1);
        chk("unf_hold", dac_data, 12'h103);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        chk("unf_clr", underflow, 0);

        // dac_ready low across two ticks, then one pop only
        dac_ready = 1'b0;
        push(12'h0A5);
        nupd = 0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            if (dac_update) nupd++;
        end
        chk("notready_upd", nupd, 0);
        chk("notready_fill", fill, 1);
        dac_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (dac_update) begin nupd++; last = dac_data; end
        end
        chk("ready_upd_cnt", nupd, 1);
        chk("ready_data", last, 12'h0A5);
        chk("ready_fill", fill, 0);

        // disable mid-RUN with fill=5
        dac_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(12'h200 + 12'(i));
        chk("fill5", fill, 5);
        en = 1'b0;
        step(1);
        chk("dis_fill", fill, 0);
        chk("dis_mic_en", mic_en, 0);
        chk("dis_upd", dac_update, 0);
        chk("dis_hold", dac_data, 12'h0A5);

        // overflow: 9 pushes into depth 8
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        en = 1'b1;
        step(1);
        for (int i = 0; i < 9; i++) push(12'h010 + 12'(i));
        chk("ovf_fill", fill, 8);
        chk("ovf_flag", overflow, 1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        chk("ovf_clr", overflow, 0);
        dac_ready = 1'b1;
        nupd = 0;
        last = 12'h000;
        for (int i = 0; i < 120; i++) begin
            step(1);
            if (dac_update) begin nupd++; last = dac_data; end
        end
        chk("drain_cnt", nupd, 8);
        chk("drain_last", last, 12'h017);
        chk("drain_fill", fill, 0);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", dac_data, 12'h800);
        chk("arst_mic_en", mic_en, 0);
        chk("arst_fill", fill, 0);
        chk("arst_unf", underflow, 0);
        chk("arst_upd", dac_update, 0);
        step(1);
        rst = 1'b0;

`ifdef PEAK_HOLD_EN
        chk("peak_rst", peak, 0);
        step(1);
        push(12'h900);
        chk("peak_900", peak, 11'h100);
        push(12'h700);
        chk("peak_700", peak, 11'h100);
        push(12'h000);
        chk("peak_000", peak, 11'h7FF);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        chk("peak_clr", peak, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
